// File: rtl/cla_pipe_adder_pkg.sv
// ============================================================================
// cla_pipe_adder_pkg : group width and the parameter legality check shared by
//                      the pipelined carry-lookahead adder and its 4-bit group.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cla_pipe_adder_pkg;

  localparam int GROUP_W = 4;

  function automatic bit params_legal(input int width, input int stages);
    return (width >= 8) && (width <= 64) && ((width % GROUP_W) == 0) &&
           (stages >= 1) && (stages <= (width / GROUP_W)) &&
           (((width / GROUP_W) % stages) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_pipe_adder_group.sv
// ============================================================================
// cla_group : one 4-bit carry-lookahead group producing its sum and the
//             group generate/propagate terms for the next lookahead level.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cla_group
  import cla_pipe_adder_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               gen,
  output logic               prop
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
    gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    prop = &p;
  end

endmodule

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// ============================================================================
// cla_pipe_adder : pipelined add/subtract; slice k resolves in stage k, upper
//                  operands ride skew registers, lower sums ride deskew regs.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE_W = WIDTH / STAGES;
  localparam int GPS     = SLICE_W / GROUP_W;

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("cla_pipe_adder: illegal WIDTH/STAGES combination");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is folded in at the input so every stage is a plain adder.
  always_comb begin
    adv     = !out_valid | out_ready;
    b_eff   = sub ? ~b : b;
    cin_eff = sub | cin;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO   = s * SLICE_W;
    localparam int IN_W = WIDTH - LO;

    logic [IN_W-1:0]       in_a;
    logic [IN_W-1:0]       in_b;
    logic                  in_c;
    logic                  in_v;
    logic [SLICE_W-1:0]    slice_sum;
    logic [GPS-1:0]        grp_g;
    logic [GPS-1:0]        grp_p;
    logic [GPS:0]          grp_c;
    logic [LO+SLICE_W-1:0] sum_d;
    logic [LO+SLICE_W-1:0] sum_q;
    logic                  carry_d;
    logic                  carry_q;
    logic                  valid_d;
    logic                  valid_q;

    if (s == 0) begin : g_src
      always_comb begin
        in_a  = a;
        in_b  = b_eff;
        in_c  = cin_eff;
        in_v  = in_valid;
        sum_d = slice_sum;
      end
    end else begin : g_src
      always_comb begin
        in_a  = g_stage[s-1].g_skew.a_q;
        in_b  = g_stage[s-1].g_skew.b_q;
        in_c  = g_stage[s-1].carry_q;
        in_v  = g_stage[s-1].valid_q;
        sum_d = {slice_sum, g_stage[s-1].sum_q};
      end
    end

    for (genvar g = 0; g < GPS; g++) begin : g_grp
      cla_group u_grp (
        .a    (in_a[g*GROUP_W +: GROUP_W]),
        .b    (in_b[g*GROUP_W +: GROUP_W]),
        .cin  (grp_c[g]),
        .sum  (slice_sum[g*GROUP_W +: GROUP_W]),
        .gen  (grp_g[g]),
        .prop (grp_p[g])
      );
    end

    // Each group carry is the flat sum-of-products of lower G/P terms.
    always_comb begin
      logic term;
      grp_c = '0;
      for (int g = 0; g <= GPS; g++) begin
        term = 1'b1;
        for (int j = g - 1; j >= 0; j--) begin
          grp_c[g] = grp_c[g] | (term & grp_g[j]);
          term     = term & grp_p[j];
        end
        grp_c[g] = grp_c[g] | (term & in_c);
      end
      carry_d = grp_c[GPS];
      valid_d = in_v;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (s < STAGES - 1) begin : g_skew
      logic [IN_W-SLICE_W-1:0] a_d;
      logic [IN_W-SLICE_W-1:0] a_q;
      logic [IN_W-SLICE_W-1:0] b_d;
      logic [IN_W-SLICE_W-1:0] b_q;

      always_comb begin
        a_d = in_a[IN_W-1:SLICE_W];
        b_d = in_b[IN_W-1:SLICE_W];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (s == STAGES - 1) begin : g_final
      logic ovf_d;
      logic ovf_q;
      logic zero_d;
      logic zero_q;

      // Carry into the MSB is recovered from the MSB sum and its operand bits.
      always_comb begin
        ovf_d  = (slice_sum[SLICE_W-1] ^ in_a[SLICE_W-1] ^ in_b[SLICE_W-1]) ^ grp_c[GPS];
        zero_d = ~|sum_d;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  always_comb begin
    in_ready  = adv;
    out_valid = g_stage[STAGES-1].valid_q;
    sum       = g_stage[STAGES-1].sum_q;
    cout      = g_stage[STAGES-1].carry_q;
    ovf       = g_stage[STAGES-1].g_final.ovf_q;
    zero      = g_stage[STAGES-1].g_final.zero_q;
  end

endmodule

`default_nettype wire
